battleship_board: RTL
=====================

# battleship_board

Parametrised game-state engine for the Battleship lab. It holds a ROWS×COLS board of 2-bit cell states and moves a cursor from one-cycle direction pulses. It runs a place → play → done phase machine and exports the packed board matrix that feeds the VGA renderer. It is the successor of the fixed 5×5 board matrix: board size and ship count are configurable, and placement, firing, scoring and game-over are handled in hardware.

## Interface
- ROWS, default 5, number of board rows, ≥2.
- COLS, default 5, number of board columns, ≥2.
- SHIPS, default 3, ship cells to place and sink, 1..ROWS*COLS.
- RW, default $clog2(ROWS), row index width (derived, do not override).
- CWID, default $clog2(COLS), column index width (derived, do not override).
- NW, default $clog2(ROWS*COLS+1), counter width (derived, do not override).
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clk cycle high is sufficient.
- up, down, left, right  in  1 each  cursor move pulses, sampled every cycle.
- place  in  1  place a ship cell at the cursor; acts only in PLACE.
- fire  in  1  shoot the cell at the cursor; acts only in PLAY.
- cells  out  2*ROWS*COLS  packed board. Cell (r,c) sits at bits [2i+1:2i], i=r*COLS+c. Encoding: 00 EMPTY, 01 SHIP, 10 HIT, 11 MISS.
- cur_row  out  RW  cursor row.
- cur_col  out  CWID  cursor column.
- phase  out  2  00 PLACE, 01 PLAY, 10 DONE (11 never produced).
- placed  out  NW  ship cells placed so far.
- hits  out  NW  ship cells hit so far.
- shots  out  NW  valid shots fired, where a shot is counted only if it lands on an EMPTY or SHIP cell.
- game_over  out  1  equals phase==DONE.

## Operation
- Reset clears all outputs to zero: every cell EMPTY, cursor at (0,0), phase PLACE, all counters 0, game_over 0.
- Cursor moves:
  - up decrements cur_row; down increments it.
  - left decrements cur_col; right increments it.
  - up and down together cancel; left and right together cancel. Row and column moves are independent, so diagonal moves are allowed.
  - At an edge the cursor saturates (0 or ROWS-1 / COLS-1), unless wrap is enabled (see Configuration).
  - Moves are accepted in PLACE and PLAY. The cursor is frozen in DONE.
- PLACE phase:
  - place on an EMPTY cell sets it to SHIP and increments placed.
  - place on a SHIP cell is ignored: no toggle, no count.
  - fire is ignored.
- PLACE → PLAY happens on the same edge that writes the SHIPS-th ship cell.
- PLAY phase:
  - fire on EMPTY sets the cell to MISS and increments shots.
  - fire on SHIP sets the cell to HIT and increments both shots and hits.
  - fire on HIT or MISS is ignored: no state change, no count.
  - place is ignored.
- PLAY → DONE happens on the same edge that records the SHIPS-th hit.
- DONE phase: all inputs are ignored until reset. cells, counters and cursor hold their values.
- Counters never overflow. placed ≤ SHIPS, hits ≤ SHIPS, shots ≤ ROWS*COLS, and NW covers ROWS*COLS.

## Timing
- All outputs are registered. A pulse sampled at edge N is visible on the outputs after edge N, with no further latency.
- Move combined with place/fire in the same cycle: the action uses the cursor value from before the edge, and the move also takes effect at that edge.
- place and fire in the same cycle: only the one valid for the current phase acts.
- Pulses held high for K cycles act K times, one per cycle. No edge detection is done inside this block; the debouncer upstream owns that.
- reset has priority over every other input. Reset mid-game returns to the reset state at that edge.

## Configuration
- CURSOR_WRAP_EN:
  - Defined: moving past an edge wraps. up at row 0 goes to ROWS-1; right at COLS-1 goes to 0; likewise for down and left.
  - Undefined: the cursor saturates at board edges.
- All other behaviour is identical in both builds.

## Test plan
- Reset then idle: cells=0, cur=(0,0), phase=00, placed=hits=shots=0, game_over=0.
- Saturation (wrap undefined): left ×3 from (0,0) → cur_col=0; right ×6 → cur_col=4; up+down together → cur_row unchanged. Wrap build: up at row 0 → cur_row=4.
- Placement (defaults): place at (0,0), place again at (0,0), then place at (1,2) and (4,4). Expected:
  - cells for i=0, 7 and 24 are 01;
  - placed=3;
  - phase=01 immediately after the third place;
  - the duplicate place is not counted.
- Firing: fire at (2,2) → cell 12 = 11, shots=1. Fire at (2,2) again → shots stays 1. Fire at (0,0) → cell 0 = 10, hits=1, shots=2.
- Game over: sink the remaining ships at (1,2) and (4,4) → hits=3, phase=10, game_over=1 on that edge. Further moves, fire and place change nothing.
- Mid-game reset: after 2 hits, assert reset for 1 cycle → all outputs return to reset values on the next cycle.

Source files
------------

// File: rtl/battleship_board.sv
// -----------------------------------------------------------------------------
// battleship_board
//
// Game-state engine for the Battleship lab. Holds a ROWS x COLS board of 2-bit
// cells, moves a cursor from one-cycle direction pulses and runs the
// PLACE -> PLAY -> DONE phase machine. The packed board feeds the VGA renderer.
//
// Build option:
//   CURSOR_WRAP_EN  defined   : cursor wraps around board edges
//                   undefined : cursor saturates at board edges
//
// Ports:
//   clk                    system clock, all state changes on the rising edge
//   reset                  synchronous active-high reset, priority over all
//   up/down/left/right     cursor move pulses (opposite pairs cancel)
//   place                  place a ship cell at the cursor (PLACE phase only)
//   fire                   shoot the cell at the cursor (PLAY phase only)
//   cells                  packed board, cell (r,c) at bits [2i+1:2i], i=r*COLS+c
//                          00 EMPTY, 01 SHIP, 10 HIT, 11 MISS
//   cur_row / cur_col      cursor position
//   phase                  00 PLACE, 01 PLAY, 10 DONE
//   placed / hits / shots  ship cells placed, ship cells hit, valid shots fired
//   game_over              high while in DONE
// -----------------------------------------------------------------------------
module battleship_board #(
    parameter int ROWS  = 5,
    parameter int COLS  = 5,
    parameter int SHIPS = 3,
    parameter int RW    = $clog2(ROWS),
    parameter int CWID  = $clog2(COLS),
    parameter int NW    = $clog2(ROWS*COLS+1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     up,
    input  logic                     down,
    input  logic                     left,
    input  logic                     right,
    input  logic                     place,
    input  logic                     fire,
    output logic [2*ROWS*COLS-1:0]   cells,
    output logic [RW-1:0]            cur_row,
    output logic [CWID-1:0]          cur_col,
    output logic [1:0]               phase,
    output logic [NW-1:0]            placed,
    output logic [NW-1:0]            hits,
    output logic [NW-1:0]            shots,
    output logic                     game_over
);

    localparam int NCELLS = ROWS * COLS;
    localparam int IW     = $clog2(NCELLS);

    localparam logic [RW-1:0]   ROW_MAX    = RW'(ROWS - 1);
    localparam logic [CWID-1:0] COL_MAX    = CWID'(COLS - 1);
    localparam logic [NW-1:0]   SHIPS_LAST = NW'(SHIPS - 1);

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_SHIP  = 2'b01;
    localparam logic [1:0] CELL_HIT   = 2'b10;
    localparam logic [1:0] CELL_MISS  = 2'b11;

`ifdef CURSOR_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        PH_PLACE = 2'b00,
        PH_PLAY  = 2'b01,
        PH_DONE  = 2'b10
    } phase_t;

    phase_t          phase_reg,   phase_next;
    logic [RW-1:0]   cur_row_reg, cur_row_next;
    logic [CWID-1:0] cur_col_reg, cur_col_next;
    logic [NW-1:0]   placed_reg,  placed_next;
    logic [NW-1:0]   hits_reg,    hits_next;
    logic [NW-1:0]   shots_reg,   shots_next;

    logic            move_en;
    logic            cell_wr_en;
    logic [1:0]      cell_wr_val;
    logic [IW-1:0]   cur_idx;
    logic [1:0]      cur_cell;
    logic [1:0]      cell_arr [NCELLS];

    // Linear index of the cell under the cursor (before this edge's move).
    assign cur_idx  = IW'(int'(cur_row_reg) * COLS + int'(cur_col_reg));
    assign cur_cell = cell_arr[cur_idx];

    // -------------------------------------------------------------------------
    // Board storage: one 2-bit register per cell. Only the cell addressed by
    // the cursor can be written in a given cycle.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < NCELLS; gi++) begin : g_cell
        logic [1:0] cell_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                cell_reg <= CELL_EMPTY;
            end else if (cell_wr_en && (cur_idx == IW'(gi))) begin
                cell_reg <= cell_wr_val;
            end
        end

        assign cell_arr[gi]     = cell_reg;
        assign cells[2*gi +: 2] = cell_reg;
    end

    // -------------------------------------------------------------------------
    // Cursor move target. Opposite pulses cancel; rows and columns are
    // independent so a diagonal step is a single cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        cur_row_next = cur_row_reg;
        if (up && !down) begin
            if (cur_row_reg == '0) begin
                cur_row_next = WRAP_EN ? ROW_MAX : '0;
            end else begin
                cur_row_next = cur_row_reg - RW'(1);
            end
        end else if (down && !up) begin
            if (cur_row_reg == ROW_MAX) begin
                cur_row_next = WRAP_EN ? '0 : ROW_MAX;
            end else begin
                cur_row_next = cur_row_reg + RW'(1);
            end
        end
    end

    always_comb begin
        cur_col_next = cur_col_reg;
        if (left && !right) begin
            if (cur_col_reg == '0) begin
                cur_col_next = WRAP_EN ? COL_MAX : '0;
            end else begin
                cur_col_next = cur_col_reg - CWID'(1);
            end
        end else if (right && !left) begin
            if (cur_col_reg == COL_MAX) begin
                cur_col_next = WRAP_EN ? '0 : COL_MAX;
            end else begin
                cur_col_next = cur_col_reg + CWID'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Phase machine: next state, board write and counter updates.
    // Actions always use the cursor position from before the edge.
    // Counters cannot overflow: placed/hits stop at SHIPS because the phase
    // leaves on that edge, and shots is bounded by the number of cells that
    // can still change from EMPTY/SHIP.
    // -------------------------------------------------------------------------
    always_comb begin
        phase_next  = phase_reg;
        placed_next = placed_reg;
        hits_next   = hits_reg;
        shots_next  = shots_reg;
        cell_wr_en  = 1'b0;
        cell_wr_val = cur_cell;
        move_en     = 1'b0;

        case (phase_reg)
            PH_PLACE: begin
                move_en = 1'b1;
                if (place && (cur_cell == CELL_EMPTY)) begin
                    cell_wr_en  = 1'b1;
                    cell_wr_val = CELL_SHIP;
                    placed_next = placed_reg + NW'(1);
                    if (placed_reg == SHIPS_LAST) begin
                        phase_next = PH_PLAY;
                    end
                end
            end
            PH_PLAY: begin
                move_en = 1'b1;
                if (fire) begin
                    if (cur_cell == CELL_EMPTY) begin
                        cell_wr_en  = 1'b1;
                        cell_wr_val = CELL_MISS;
                        shots_next  = shots_reg + NW'(1);
                    end else if (cur_cell == CELL_SHIP) begin
                        cell_wr_en  = 1'b1;
                        cell_wr_val = CELL_HIT;
                        shots_next  = shots_reg + NW'(1);
                        hits_next   = hits_reg + NW'(1);
                        if (hits_reg == SHIPS_LAST) begin
                            phase_next = PH_DONE;
                        end
                    end
                end
            end
            default: begin
                // DONE: everything frozen until reset.
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_reg   <= PH_PLACE;
            cur_row_reg <= '0;
            cur_col_reg <= '0;
            placed_reg  <= '0;
            hits_reg    <= '0;
            shots_reg   <= '0;
        end else begin
            phase_reg   <= phase_next;
            placed_reg  <= placed_next;
            hits_reg    <= hits_next;
            shots_reg   <= shots_next;
            if (move_en) begin
                cur_row_reg <= cur_row_next;
                cur_col_reg <= cur_col_next;
            end
        end
    end

    assign cur_row   = cur_row_reg;
    assign cur_col   = cur_col_reg;
    assign phase     = phase_reg;
    assign placed    = placed_reg;
    assign hits      = hits_reg;
    assign shots     = shots_reg;
    assign game_over = (phase_reg == PH_DONE);

endmodule
